result_checker: RTL and testbench
=================================

RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, expected-queue entries; a power of two, at least 2.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_push  input  1  driven operands valid this cycle.
REQ-006 SHALL have ports i_a, i_b  input  WIDTH  operands applied to the DUT.
REQ-007 SHALL have port i_s_valid  input  1  DUT result valid this cycle.
REQ-008 SHALL have port i_s  input  WIDTH  DUT sum.
REQ-009 SHALL have port i_clear  input  1  leave HALT; flush the queue.
REQ-010 SHALL have port o_event  output  4  one-cycle pulses: [0] match, [1] mismatch, [2] overflow, [3] underflow.
REQ-011 SHALL have port o_err_ctr  output  8  saturating mismatch count.
REQ-012 SHALL have ports o_full, o_empty  output  1  queue status.
REQ-013 SHALL have port o_count  output  $clog2(DEPTH)+1  occupancy.
REQ-014 SHALL have port o_state  output  2  IDLE=0, ACTIVE=1, HALT=2.

Function
REQ-015 SHALL push {i_a, i_b} into a DEPTH-entry FIFO when i_push=1, the queue is not full, and the state is not HALT.
REQ-016 SHALL pop the oldest entry when i_s_valid=1 and the queue is non-empty, and compare i_s against (a+b) mod 2^WIDTH, carry discarded.
REQ-017 SHALL assert o_event[0] on equality or o_event[1] on inequality exactly one cycle after the popping cycle.
REQ-018 SHALL increment o_err_ctr on each mismatch pulse and hold it at 255.
REQ-019 SHALL accept a push and a pop in the same cycle when full: count unchanged, no overflow.
REQ-020 SHALL treat i_s_valid on an empty queue as underflow, including a same-cycle push (no bypass): pulse o_event[3] next cycle, keep the push.
REQ-021 SHALL treat i_push while full without a same-cycle pop as overflow: drop the operands, pulse o_event[2] next cycle, enter HALT.
REQ-022 SHALL wrap read/write pointers modulo DEPTH; o_full = (count==DEPTH), o_empty = (count==0).
REQ-023 SHALL transition IDLE->ACTIVE on the first accepted push; ACTIVE->IDLE when count reaches 0; any->HALT on overflow.
REQ-024 SHALL, in HALT, ignore i_push, keep popping and comparing on i_s_valid, and return to IDLE on i_clear.
REQ-025 SHALL, on i_clear in any state, empty the queue next cycle; o_err_ctr is retained; a same-cycle push or pop is discarded.
REQ-026 SHALL give i_clear priority over overflow and underflow detection in the same cycle.

Reset
REQ-027 SHALL on reset set state IDLE, pointers and count 0, o_event 0, o_err_ctr 0, o_empty 1, o_full 0.
REQ-028 SHALL let reset override all inputs, including mid-operation with a full queue; queue contents need not be cleared.

Configuration
REQ-029 SHALL, with RESULT_CHECKER_CAPTURE_EN defined, add outputs o_cap_a, o_cap_b, o_cap_s (WIDTH each) and o_cap_valid (1).
REQ-030 SHALL, with RESULT_CHECKER_CAPTURE_EN defined, latch the operands and result of the first mismatch since reset or i_clear, set o_cap_valid, and zero all four on reset or i_clear.
REQ-031 SHALL, without RESULT_CHECKER_CAPTURE_EN, omit the capture ports and registers entirely.

Verification
REQ-032 SHALL cover: push a=3, b=5, then i_s_valid with s=8 -> o_event=0001 one cycle later; err_ctr stays 0.
REQ-033 SHALL cover: push a=FFFFFFFF, b=1, then s=0 -> match (wrap); s=1 instead -> mismatch, err_ctr=1, capture shows a=FFFFFFFF, b=1, s=1 (macro on).
REQ-034 SHALL cover: 8 pushes with DEPTH=8, then a 9th push alone -> o_full=1, o_event[2] pulse, state HALT, count stays 8.
REQ-035 SHALL cover: with a full queue, push and pop in the same cycle -> count 8, no overflow pulse, popped entry compared.
REQ-036 SHALL cover: i_s_valid on an empty queue with a same-cycle push -> o_event[3] pulse, count becomes 1.
REQ-037 SHALL cover: 300 consecutive mismatches -> err_ctr=255; then i_clear -> count 0, state IDLE, err_ctr still 255.

Source files
------------

// File: rtl/result_checker.sv
// Scoreboard for an adder DUT: queues operand pairs, checks each returned sum in order.
// Optional first-mismatch capture ports are built when RESULT_CHECKER_CAPTURE_EN is defined.
module result_checker #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_a,
    input  logic [WIDTH-1:0]         i_b,
    input  logic                     i_s_valid,
    input  logic [WIDTH-1:0]         i_s,
    input  logic                     i_clear,
    output logic [3:0]               o_event,
    output logic [7:0]               o_err_ctr,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [1:0]               o_state
`ifdef RESULT_CHECKER_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]         o_cap_a,
    output logic [WIDTH-1:0]         o_cap_b,
    output logic [WIDTH-1:0]         o_cap_s,
    output logic                     o_cap_valid
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HALT   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [WIDTH-1:0] sum;
    logic             full, empty;
    logic             pop, push_ok, overflow, underflow, match, mismatch;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign o_full  = full;
    assign o_empty = empty;
    assign o_count = count;
    assign o_state = state;

    // Clear suppresses every same-cycle action, including error detection.
    always_comb begin
        sum       = mem_a[rd_ptr] + mem_b[rd_ptr];
        pop       = i_s_valid && !empty && !i_clear;
        push_ok   = i_push && (state != HALT) && (!full || pop) && !i_clear;
        overflow  = i_push && (state != HALT) && full && !pop && !i_clear;
        underflow = i_s_valid && empty && !i_clear;
        match     = pop && (i_s == sum);
        mismatch  = pop && (i_s != sum);
        case ({push_ok, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (i_clear) begin
            state_nxt = IDLE;
        end else if (overflow) begin
            state_nxt = HALT;
        end else begin
            case (state)
                IDLE:    if (push_ok) state_nxt = ACTIVE;
                ACTIVE:  if (count_nxt == '0) state_nxt = IDLE;
                HALT:    state_nxt = HALT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_event   <= '0;
            o_err_ctr <= '0;
        end else begin
            state   <= state_nxt;
            o_event <= {underflow, overflow, mismatch, match};
            if (mismatch && (o_err_ctr != 8'hFF))
                o_err_ctr <= o_err_ctr + 8'd1;
            if (i_clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
                count <= count_nxt;
            end
        end
    end

    // Storage needs no reset: only entries below count are ever read as valid.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem_a[wr_ptr] <= i_a;
            mem_b[wr_ptr] <= i_b;
        end
    end

`ifdef RESULT_CHECKER_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            o_cap_a     <= '0;
            o_cap_b     <= '0;
            o_cap_s     <= '0;
            o_cap_valid <= 1'b0;
        end else if (mismatch && !o_cap_valid) begin
            o_cap_a     <= mem_a[rd_ptr];
            o_cap_b     <= mem_b[rd_ptr];
            o_cap_s     <= i_s;
            o_cap_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker: queue-based reference model checked every cycle,
// plus literal spot checks on the scenarios of interest.
module tb_result_checker;

    localparam int W = 32;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_push = 1'b0;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         i_s_valid = 1'b0;
    logic [W-1:0] i_s = '0;
    logic         i_clear = 1'b0;
    logic [3:0]   o_event;
    logic [7:0]   o_err_ctr;
    logic         o_full, o_empty;
    logic [3:0]   o_count;
    logic [1:0]   o_state;
`ifdef RESULT_CHECKER_CAPTURE_EN
    logic [W-1:0] o_cap_a, o_cap_b, o_cap_s;
    logic         o_cap_valid;
`endif

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    result_checker #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .i_push(i_push), .i_a(i_a), .i_b(i_b),
        .i_s_valid(i_s_valid), .i_s(i_s), .i_clear(i_clear),
        .o_event(o_event), .o_err_ctr(o_err_ctr), .o_full(o_full),
        .o_empty(o_empty), .o_count(o_count), .o_state(o_state)
`ifdef RESULT_CHECKER_CAPTURE_EN
        , .o_cap_a(o_cap_a), .o_cap_b(o_cap_b), .o_cap_s(o_cap_s),
        .o_cap_valid(o_cap_valid)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queue of operand pairs and integer bookkeeping.
    logic [2*W-1:0] exp_q[$];
    int             m_state = 0;
    int             m_err = 0;
    logic [3:0]     m_ev = '0;
    logic [2*W-1:0] m_ent;
    logic [W-1:0]   m_sum;
    int             m_sz0;
    bit             m_pop;
    bit             m_cap_v = 0;
    logic [W-1:0]   m_cap_a = '0, m_cap_b = '0, m_cap_s = '0;

    always @(posedge clk) begin
        m_ev = '0;
        if (reset) begin
            exp_q.delete();
            m_state = 0;
            m_err = 0;
            m_cap_v = 0; m_cap_a = '0; m_cap_b = '0; m_cap_s = '0;
        end else if (i_clear) begin
            exp_q.delete();
            m_state = 0;
            m_cap_v = 0; m_cap_a = '0; m_cap_b = '0; m_cap_s = '0;
        end else begin
            m_sz0 = exp_q.size();
            m_pop = i_s_valid && (m_sz0 > 0);
            if (i_s_valid && m_sz0 == 0) m_ev[3] = 1'b1;
            if (m_pop) begin
                m_ent = exp_q.pop_front();
                m_sum = m_ent[2*W-1:W] + m_ent[W-1:0];
                if (i_s == m_sum) m_ev[0] = 1'b1;
                else begin
                    m_ev[1] = 1'b1;
                    if (m_err < 255) m_err++;
                    if (!m_cap_v) begin
                        m_cap_v = 1; m_cap_a = m_ent[2*W-1:W]; m_cap_b = m_ent[W-1:0]; m_cap_s = i_s;
                    end
                end
            end
            if (i_push && m_state != 2) begin
                if (m_sz0 < D || m_pop) begin
                    exp_q.push_back({i_a, i_b});
                    if (m_state == 0) m_state = 1;
                end else begin
                    m_ev[2] = 1'b1;
                    m_state = 2;
                end
            end
            if (m_state == 1 && exp_q.size() == 0) m_state = 0;
        end
        #1;
        chk("event", 32'(o_event), 32'(m_ev));
        chk("err_ctr", 32'(o_err_ctr), 32'(m_err));
        chk("count", 32'(o_count), 32'(exp_q.size()));
        chk("full", 32'(o_full), 32'(exp_q.size() == D));
        chk("empty", 32'(o_empty), 32'(exp_q.size() == 0));
        chk("state", 32'(o_state), 32'(m_state));
`ifdef RESULT_CHECKER_CAPTURE_EN
        chk("cap_valid", 32'(o_cap_valid), 32'(m_cap_v));
        chk("cap_a", o_cap_a, m_cap_a);
        chk("cap_b", o_cap_b, m_cap_b);
        chk("cap_s", o_cap_s, m_cap_s);
`endif
    end

    // One clock of stimulus; returns 2 time units after the edge so outputs are settled.
    task automatic cyc(input logic rst, input logic p, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sv, input logic [W-1:0] s, input logic clr);
        @(negedge clk);
        reset = rst; i_push = p; i_a = a; i_b = b; i_s_valid = sv; i_s = s; i_clear = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(0, 0, '0, '0, 0, '0, 0);
    endtask

    initial begin
        cyc(1, 0, '0, '0, 0, '0, 0);
        cyc(1, 1, 32'd7, 32'd7, 1, '0, 1);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_event", 32'(o_event), 32'd0);
        chk("rst_err", 32'(o_err_ctr), 32'd0);

        // 3 + 5 = 8
        cyc(0, 1, 32'd3, 32'd5, 0, '0, 0);
        chk("push_state", 32'(o_state), 32'd1);
        chk("push_count", 32'(o_count), 32'd1);
        cyc(0, 0, '0, '0, 1, 32'd8, 0);
        chk("match_3_5", 32'(o_event), 32'b0001);
        chk("match_err", 32'(o_err_ctr), 32'd0);
        chk("match_idle", 32'(o_state), 32'd0);
        idle();
        chk("event_one_cycle", 32'(o_event), 32'd0);

        // Wrap-around sum, then a mismatch on the same operands
        cyc(0, 1, 32'hFFFF_FFFF, 32'd1, 0, '0, 0);
        cyc(0, 0, '0, '0, 1, 32'd0, 0);
        chk("wrap_match", 32'(o_event), 32'b0001);
        cyc(0, 1, 32'hFFFF_FFFF, 32'd1, 0, '0, 0);
        cyc(0, 0, '0, '0, 1, 32'd1, 0);
        chk("wrap_mismatch", 32'(o_event), 32'b0010);
        chk("wrap_err", 32'(o_err_ctr), 32'd1);
`ifdef RESULT_CHECKER_CAPTURE_EN
        chk("cap_a_lit", o_cap_a, 32'hFFFF_FFFF);
        chk("cap_b_lit", o_cap_b, 32'd1);
        chk("cap_s_lit", o_cap_s, 32'd1);
        chk("cap_v_lit", 32'(o_cap_valid), 32'd1);
`endif

        // Fill, then overflow into HALT
        for (int i = 0; i < D; i++) cyc(0, 1, 32'(i + 1), 32'(10 * i), 0, '0, 0);
        chk("fill_full", 32'(o_full), 32'd1);
        chk("fill_count", 32'(o_count), 32'd8);
        cyc(0, 1, 32'd99, 32'd1, 0, '0, 0);
        chk("ovf_event", 32'(o_event), 32'b0100);
        chk("ovf_state", 32'(o_state), 32'd2);
        chk("ovf_count", 32'(o_count), 32'd8);
        cyc(0, 0, '0, '0, 0, '0, 1);
        chk("clr_count", 32'(o_count), 32'd0);
        chk("clr_state", 32'(o_state), 32'd0);
        chk("clr_err", 32'(o_err_ctr), 32'd1);

        // Full queue: push and pop together is not an overflow
        for (int i = 0; i < D; i++) cyc(0, 1, 32'(i), 32'(i + 100), 0, '0, 0);
        cyc(0, 1, 32'd7, 32'd7, 1, 32'd100, 0);
        chk("fullpp_event", 32'(o_event), 32'b0001);
        chk("fullpp_count", 32'(o_count), 32'd8);
        chk("fullpp_state", 32'(o_state), 32'd1);
        cyc(0, 1, 32'd1, 32'd1, 0, '0, 0);
        chk("ovf2_state", 32'(o_state), 32'd2);
        // HALT: push ignored, pop still compared
        cyc(0, 1, 32'd5, 32'd5, 1, 32'd102, 0);
        chk("halt_event", 32'(o_event), 32'b0001);
        chk("halt_count", 32'(o_count), 32'd7);
        chk("halt_state", 32'(o_state), 32'd2);
        cyc(0, 1, 32'd5, 32'd5, 1, 32'd0, 1);
        chk("clr_pp_count", 32'(o_count), 32'd0);
        chk("clr_pp_state", 32'(o_state), 32'd0);
        chk("clr_pp_event", 32'(o_event), 32'd0);

        // Underflow with same-cycle push: no bypass, push kept
        cyc(0, 1, 32'd4, 32'd4, 1, 32'd8, 0);
        chk("udf_event", 32'(o_event), 32'b1000);
        chk("udf_count", 32'(o_count), 32'd1);
        cyc(0, 0, '0, '0, 1, 32'd8, 0);
        chk("udf_drain", 32'(o_event), 32'b0001);
        cyc(0, 0, '0, '0, 1, '0, 1);
        chk("clr_udf_prio", 32'(o_event), 32'd0);

        // 300 mismatches saturate the error counter
        cyc(0, 1, 32'd1, 32'd1, 0, '0, 0);
        for (int i = 0; i < 300; i++) cyc(0, 1, 32'd1, 32'd1, 1, 32'd0, 0);
        chk("sat_err", 32'(o_err_ctr), 32'd255);
        chk("sat_event", 32'(o_event), 32'b0010);
`ifdef RESULT_CHECKER_CAPTURE_EN
        chk("sat_cap_s", o_cap_s, 32'd0);
        chk("sat_cap_a", o_cap_a, 32'd1);
`endif
        cyc(0, 0, '0, '0, 0, '0, 1);
        chk("sat_clr_count", 32'(o_count), 32'd0);
        chk("sat_clr_state", 32'(o_state), 32'd0);
        chk("sat_clr_err", 32'(o_err_ctr), 32'd255);

        // Reset with a full queue and busy inputs
        for (int i = 0; i < D; i++) cyc(0, 1, 32'(i * 3), 32'(i), 0, '0, 0);
        cyc(1, 1, 32'd2, 32'd2, 1, 32'd0, 0);
        chk("midrst_count", 32'(o_count), 32'd0);
        chk("midrst_empty", 32'(o_empty), 32'd1);
        chk("midrst_err", 32'(o_err_ctr), 32'd0);
        chk("midrst_state", 32'(o_state), 32'd0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
